// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops words from a first-word-fall-through FIFO and serialises each one onto
// an asynchronous UART line: start bit, data LSB first, optional parity bit,
// then one or two stop bits. Frames run back-to-back while words are available
// and enable is high.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      allows new frames to start (a running frame always completes)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word (valid while fifo_empty=0)
//   fifo_rd_en  one-cycle pop strobe, issued on the cycle the word is captured
//   tx          serial line, idles high
//   busy        high whenever a frame is in progress
//   frame_done  one-cycle pulse after the last stop-bit cycle
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a captured word; odd parity is the inverted XOR.
  function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
    return (^w) ^ (PARITY_ODD != 0);
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end_s;
  logic                  start_ok_s;
  logic                  launch_s;

  assign bit_end_s  = (baud_q == BAUD_LAST);
  assign start_ok_s = enable & ~fifo_empty;

  // Next-state logic: bit timing, frame sequencing and word capture.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
    launch_s = 1'b0;

    // The baud counter only runs inside a frame and wraps on every bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = bit_end_s ? '0 : (baud_q + BAUD_ONE);
    end else begin
      baud_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          idx_d   = '0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          idx_d   = '0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (idx_q == STOP_LAST) begin
            done_d = 1'b1;
            idx_d  = '0;
            // Re-check for another word so consecutive frames have no gap.
            if (start_ok_s) begin
              launch_s = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase

    // Capture the head word and pop it; the FIFO advances on the next edge.
    if (launch_s) begin
      shift_d = fifo_data;
      par_d   = word_parity(fifo_data);
      rd_en_d = 1'b1;
      state_d = S_START;
      baud_d  = '0;
      idx_d   = '0;
    end else begin
      rd_en_d = 1'b0;
    end
  end

  // Line level follows the state being entered so tx is registered with no lag.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx with CLKS_PER_BIT=4. One instance without
// parity is fed by a small FIFO model; two parity instances (even and odd)
// share a single-word source.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  // FIFO model feeding the main instance
  logic [7:0] mem [0:15];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en, tx, busy, frame_done;
  int         pop_count = 0;
  int         fd_count  = 0;
  int         bad_pop   = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_ptr    <= rd_ptr + 5'd1;
      pop_count <= pop_count + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
    if (frame_done) fd_count <= fd_count + 1;
  end

  // Single-word source for the parity instances
  logic       p_empty;
  logic [7:0] p_data;
  logic       pe_rd_en, pe_tx, pe_busy, pe_done;
  logic       po_rd_en, po_tx, po_busy, po_done;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_en), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(p_empty), .fifo_data(p_data),
    .fifo_rd_en(pe_rd_en), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_done));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(p_empty), .fifo_data(p_data),
    .fifo_rd_en(po_rd_en), .tx(po_tx), .busy(po_busy), .frame_done(po_done));

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  // Checks one 40-cycle frame of the main instance; pat bit i is bit time i.
  task automatic check_frame(input string name, input logic [9:0] pat, input int drop_at);
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== pat[n / CPB]) begin
        n_fail++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, n, tx, pat[n / CPB]);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected 1", name, n, busy);
      end
      n_checks++;
      if (rd_en !== (n == 0)) begin
        n_fail++;
        $display("FAIL %s rd_en cycle %0d: got %b expected %b", name, n, rd_en, (n == 0));
      end
      if (n == drop_at) enable = 1'b0;
    end
  endtask

  task automatic check_end(input string name);
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_done: got %b expected 1", name, frame_done);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after frame: got %b expected 0", name, busy);
    end
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tx after frame: got %b expected 1", name, tx);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    p_empty = 1'b1;
    p_data  = 8'h07;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx, rd_en, busy, frame_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset main {tx,rd,busy,done}: got %b expected 1000", {tx, rd_en, busy, frame_done});
    end
    n_checks++;
    if ({pe_tx, pe_rd_en, pe_busy, pe_done, po_tx, po_rd_en, po_busy, po_done} !== 8'b10001000) begin
      n_fail++;
      $display("FAIL reset parity outputs: got %b expected 10001000",
               {pe_tx, pe_rd_en, pe_busy, pe_done, po_tx, po_rd_en, po_busy, po_done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    enable = 1'b1;
    push(8'hA5);
    check_frame("a5", 10'b1101001010, -1);
    check_end("a5");
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL a5 frame_done width: got %b expected 0", frame_done);
    end
    n_checks++;
    if (pop_count !== 1 || fd_count !== 1 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL a5 counts: pops %0d done %0d empty %b expected 1 1 1", pop_count, fd_count, fifo_empty);
    end
  endtask

  task automatic test_back_to_back();
    int pc0 = pop_count;
    int fd0 = fd_count;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check_frame("b2b_01", 10'b1000000010, -1);
    check_frame("b2b_02", 10'b1000000100, -1);
    check_frame("b2b_03", 10'b1000000110, -1);
    check_end("b2b");
    @(negedge clk);
    n_checks++;
    if (pop_count - pc0 !== 3 || fd_count - fd0 !== 3 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b counts: pops %0d done %0d empty %b expected 3 3 1", pop_count - pc0, fd_count - fd0, fifo_empty);
    end
  endtask

  task automatic test_idle_empty();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, rd_en, busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL idle cycle %0d {tx,rd,busy}: got %b expected 100", n, {tx, rd_en, busy});
      end
    end
  endtask

  task automatic test_parity();
    logic [10:0] pe_pat = 11'b11000001110;
    logic [10:0] po_pat = 11'b10000001110;
    p_empty = 1'b0;
    for (int n = 0; n < 11 * CPB; n++) begin
      @(negedge clk);
      n_checks++;
      if (pe_rd_en !== (n == 0) || po_rd_en !== (n == 0)) begin
        n_fail++;
        $display("FAIL parity rd_en cycle %0d: got %b%b expected %b", n, pe_rd_en, po_rd_en, (n == 0));
      end
      if (n == 0) p_empty = 1'b1;
      n_checks++;
      if (pe_tx !== pe_pat[n / CPB]) begin
        n_fail++;
        $display("FAIL parity_even tx cycle %0d: got %b expected %b", n, pe_tx, pe_pat[n / CPB]);
      end
      n_checks++;
      if (po_tx !== po_pat[n / CPB]) begin
        n_fail++;
        $display("FAIL parity_odd tx cycle %0d: got %b expected %b", n, po_tx, po_pat[n / CPB]);
      end
      n_checks++;
      if (pe_busy !== 1'b1 || po_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL parity busy cycle %0d: got %b%b expected 11", n, pe_busy, po_busy);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({pe_done, po_done, pe_busy, po_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL parity end {done,done,busy,busy}: got %b expected 1100", {pe_done, po_done, pe_busy, po_busy});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] pat = 10'b1010110100;
    int pc0 = pop_count;
    int fd0;
    push(8'h5A);
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== pat[n / CPB]) begin
        n_fail++;
        $display("FAIL rst5a tx cycle %0d: got %b expected %b", n, tx, pat[n / CPB]);
      end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({tx, busy, rd_en, frame_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst5a async {tx,busy,rd,done}: got %b expected 1000", {tx, busy, rd_en, frame_done});
    end
    @(negedge clk);
    reset = 1'b0;
    fd0 = fd_count;
    n_checks++;
    if (pop_count - pc0 !== 1 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst5a pop: pops %0d empty %b expected 1 1", pop_count - pc0, fifo_empty);
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, rd_en} !== 3'b100) begin
        n_fail++;
        $display("FAIL rst5a after cycle %0d {tx,busy,rd}: got %b expected 100", n, {tx, busy, rd_en});
      end
    end
    n_checks++;
    if (pop_count - pc0 !== 1 || fd_count - fd0 !== 0) begin
      n_fail++;
      $display("FAIL rst5a final: pops %0d done %0d expected 1 0", pop_count - pc0, fd_count - fd0);
    end
  endtask

  task automatic test_enable_drop();
    int pc0 = pop_count;
    push(8'h3C);
    push(8'hC3);
    check_frame("drop_3c", 10'b1001111000, 1);
    check_end("drop_3c");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, rd_en} !== 3'b100) begin
        n_fail++;
        $display("FAIL drop hold cycle %0d {tx,busy,rd}: got %b expected 100", n, {tx, busy, rd_en});
      end
    end
    n_checks++;
    if (pop_count - pc0 !== 1 || (wr_ptr - rd_ptr) !== 5'd1 || fifo_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL drop fifo: pops %0d level %0d head %h expected 1 1 c3", pop_count - pc0, wr_ptr - rd_ptr, fifo_data);
    end
    enable = 1'b1;
    check_frame("resume_c3", 10'b1110000110, -1);
    check_end("resume_c3");
    @(negedge clk);
    n_checks++;
    if (pop_count - pc0 !== 2 || fifo_empty !== 1'b1 || bad_pop !== 0) begin
      n_fail++;
      $display("FAIL resume counts: pops %0d empty %b bad %0d expected 2 1 0", pop_count - pc0, fifo_empty, bad_pop);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_idle_empty();
    test_parity();
    test_reset_mid_frame();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
